// File: rtl/wb_tagged_ram.sv
// Wishbone B4 slave: byte-addressable data RAM with a parallel 4-bit tag per
// 16-byte granule, fixed wait-state latency and a sticky fault flag.
module wb_tagged_ram #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        O_fault,
  input  logic        I_fault_clr
);

  localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned TAGS  = 2 ** (ADDR_WIDTH - 2);

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_TAG  = 4'b0101;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        fault_q, fault_d;

  logic [31:0] mem_q [WORDS];
  logic [3:0]  tag_q [TAGS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-3:0] tag_idx;
  logic                  in_win, sel_ok, bad, exec_c;
  logic [31:0]           rd_word, rd_data, wr_data;
  logic [3:0]            wr_be;
  logic                  mem_we, tag_we;

  // Decode the captured request: legality, lane enables and read data.
  always_comb begin
    word_idx = adr_q[ADDR_WIDTH+1:2];
    tag_idx  = adr_q[ADDR_WIDTH+1:4];
    in_win   = (adr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    rd_word  = mem_q[word_idx];
    sel_ok   = 1'b0;
    rd_data  = '0;
    wr_data  = dat_q;
    wr_be    = 4'b0000;
    case (sel_q)
      SEL_WORD: begin
        sel_ok  = (adr_q[1:0] == 2'b00);
        rd_data = rd_word;
        wr_be   = 4'b1111;
      end
      SEL_HALF: begin
        sel_ok  = !adr_q[0];
        rd_data = adr_q[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
        wr_data = {2{dat_q[15:0]}};
        wr_be   = adr_q[1] ? 4'b1100 : 4'b0011;
      end
      SEL_BYTE: begin
        sel_ok  = 1'b1;
        case (adr_q[1:0])
          2'd0:    rd_data = {24'h0, rd_word[7:0]};
          2'd1:    rd_data = {24'h0, rd_word[15:8]};
          2'd2:    rd_data = {24'h0, rd_word[23:16]};
          default: rd_data = {24'h0, rd_word[31:24]};
        endcase
        wr_data = {4{dat_q[7:0]}};
        wr_be   = 4'(4'b0001 << adr_q[1:0]);
      end
      SEL_TAG: begin
        sel_ok  = 1'b1;
        rd_data = {28'h0, tag_q[tag_idx]};
      end
      default: sel_ok = 1'b0;
    endcase
    bad    = !in_win || !sel_ok;
    exec_c = (state_q == WAIT) && CYC_I && (cnt_q == 4'd0);
    mem_we = exec_c && we_q && !bad && (sel_q != SEL_TAG);
    tag_we = exec_c && we_q && !bad && (sel_q == SEL_TAG);
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    dat_o_d = dat_o_q;
    fault_d = fault_q;
    if (I_fault_clr) fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (CYC_I && STB_I) begin
          adr_d   = ADR_I;
          dat_d   = DAT_I;
          sel_d   = SEL_I;
          we_d    = WE_I;
          cnt_d   = 4'(WAIT_STATES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!CYC_I) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          dat_o_d = (!we_q && !bad) ? rd_data : 32'h0;
          if (bad) fault_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!STB_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      dat_o_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      dat_o_q <= dat_o_d;
      fault_q <= fault_d;
    end
  end

  // Storage arrays; contents survive reset.
  always_ff @(posedge CLK_I) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (tag_we) tag_q[tag_idx] <= dat_q[3:0];
  end

  assign DAT_O   = dat_o_q;
  assign ACK_O   = ack_q;
  assign O_fault = fault_q;

endmodule
